ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the opposite direction of the existing keyboard receive path.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, using open-drain CLK/DAT control.
- Sits in the top level beside the PS/2 receiver on clock_25. The top level drives each pin low when the matching *_oe is 1, otherwise 'z'.
- Reports completion, device ACK, or error to the issuing logic.

Parameters:
- INHIBIT_CYCLES, 3000: clock_25 cycles CLK is held low before the start bit (120 us).
- FIRST_TIMEOUT, 375000: max cycles from CLK release to the first device falling edge (15 ms).
- EDGE_TIMEOUT, 50000: max cycles between consecutive device falling edges (2 ms).
- FILTER_LEN, 8: consecutive equal samples needed to accept a new filtered CLK level.

Ports:
- clock_25  in  1  system clock, 25 MHz.
- RESET_N  in  1  reset, synchronous, active-low.
- tx_data  in  8  byte to send; sampled when tx_start is accepted.
- tx_start  in  1  one-cycle request; ignored while tx_busy=1.
- tx_busy  out  1  high from the accept cycle until done or error.
- tx_done  out  1  one-cycle pulse; byte sent and device ACK seen.
- tx_error  out  1  one-cycle pulse; timeout or missing ACK.
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.

Behaviour:
- Reset: RESET_N=0 sampled at a clock_25 edge gives state IDLE; tx_busy, tx_done, tx_error, ps2_clk_oe and ps2_dat_oe all 0; counters cleared. This applies mid-transfer too: both lines are released on the next edge and the frame is abandoned.
- Input conditioning:
  - ps2_clk_in and ps2_dat_in each pass through a 2-flop synchroniser.
  - CLK is then filtered: the filtered level changes only after FILTER_LEN identical samples.
  - fall = filtered CLK 1->0, a one-cycle pulse.
- Frame format: start 0, d0..d7 LSB first, odd parity = ~^tx_data, stop 1, then device ACK (device drives DAT low).
- State machine:
  - IDLE: outputs released. tx_start=1 latches tx_data and parity, sets tx_busy=1, goes to INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES. On the final cycle set dat_oe=1 (start bit). Next cycle clk_oe=0 (release) and go to WAIT_FIRST.
  - WAIT_FIRST: dat_oe stays 1. On fall, drive bit0 (dat_oe = ~d0), bitcnt=1, go to SHIFT. Timer reaching FIRST_TIMEOUT goes to ERR.
  - SHIFT: on each fall with bitcnt=1..7 drive d[bitcnt]. On bitcnt=8 drive parity (dat_oe = ~parity). On bitcnt=9 release DAT (stop) and go to ACK. bitcnt increments on every fall. Timer restarts on each fall; reaching EDGE_TIMEOUT goes to ERR.
  - ACK: on the next fall, sample the synchronised DAT. 0 goes to WAIT_IDLE; 1 goes to ERR. EDGE_TIMEOUT applies.
  - WAIT_IDLE: wait until filtered CLK=1 and synchronised DAT=1, then pulse tx_done and go to IDLE. EDGE_TIMEOUT applies and goes to ERR.
  - ERR: release both lines, pulse tx_error for one cycle, go to IDLE. tx_busy falls in that same cycle.
- tx_busy deasserts in the same cycle as the tx_done or tx_error pulse. A new tx_start is accepted the cycle after.
- tx_done and tx_error are never asserted in the same cycle.
- dat_oe changes only on fall cycles, or at INHIBIT end and on error/reset release. It never changes while filtered CLK is high.
- The timer is wide enough for FIRST_TIMEOUT (19 bits). It saturates and never wraps.
- tx_start in the same cycle as RESET_N=0 is ignored; reset wins.
- The receiver must ignore bus activity while tx_busy=1. That gating is top-level glue, not part of this block.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, WAIT_FIRST, SHIFT, ACK, WAIT_IDLE, ERR);
  - default timing constants for 25 MHz;
  - odd-parity function.
- One sub-module, ps2_line_filter: synchroniser, FILTER_LEN debounce and fall-pulse generator. It is reusable by the receive side.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and driving ACK.
  - CLK held low exactly 3000 cycles.
  - Bits sampled on device rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - One tx_done pulse; tx_error stays 0.
- Send 0x01 -> parity bit 0.
- Send 0x00 -> parity bit 1.
- Both cases: tx_done pulses.
- Device model omits ACK (DAT high at the 11th fall) -> one tx_error pulse, tx_done=0, both oe released.
- Device never clocks after release -> tx_error exactly FIRST_TIMEOUT cycles after clk_oe falls. Device stalls after bit 4 -> tx_error after EDGE_TIMEOUT.
- Glitch and busy checks:
  - 3-cycle low glitch on CLK during SHIFT -> no bit advance.
  - tx_start pulsed mid-frame -> ignored; the original byte completes.
- RESET_N=0 during SHIFT at bit 5 -> next cycle both oe=0, tx_busy=0, no done/error pulse. A following 0xFF transfer then completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, 25 MHz timing defaults
// and the odd-parity helper used by both directions of the port.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    WAIT_FIRST,
    SHIFT,
    ACK,
    WAIT_IDLE,
    ERR
  } ps2_tx_state_t;

  localparam int unsigned PS2_INHIBIT_CYCLES = 3000;    // 120 us
  localparam int unsigned PS2_FIRST_TIMEOUT  = 375000;  // 15 ms
  localparam int unsigned PS2_EDGE_TIMEOUT   = 50000;   // 2 ms
  localparam int unsigned PS2_FILTER_LEN     = 8;
  localparam int          PS2_TIMER_W        = 19;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronisers on CLK and DAT, CLK debounce
// needing FILTER_LEN equal samples, and a one-cycle pulse on each filtered CLK fall.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clock_25,
  input  logic RESET_N,
  input  logic clk_raw,
  input  logic dat_raw,
  output logic clk_level,
  output logic dat_level,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [CW-1:0] cnt;

  assign dat_level = dat_sync[1];

  // Idle bus is high, so synchronisers and filter come out of reset at 1.
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      clk_sync  <= 2'b11;
      dat_sync  <= 2'b11;
      clk_level <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], clk_raw};
      dat_sync <= {dat_sync[0], dat_raw};
      fall     <= 1'b0;
      if (clk_sync[1] == clk_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        clk_level <= clk_sync[1];
        fall      <= clk_level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter driving open-drain CLK/DAT enables.
// One byte per request; tx_start is ignored while tx_busy, result reported by tx_done/tx_error pulse.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned FIRST_TIMEOUT  = PS2_FIRST_TIMEOUT,
  parameter int unsigned EDGE_TIMEOUT   = PS2_EDGE_TIMEOUT,
  parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN
) (
  input  logic       clock_25,
  input  logic       RESET_N,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int TW = PS2_TIMER_W;
  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_AT   = TW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] FIRST_LAST = TW'(FIRST_TIMEOUT - 1);
  localparam logic [TW-1:0] EDGE_LAST  = TW'(EDGE_TIMEOUT - 1);

  ps2_tx_state_t state, state_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          parity_q, parity_nxt;
  logic [3:0]    bitcnt_q, bitcnt_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic          timer_clr, go_err;
  logic          busy_nxt, done_nxt, error_nxt, clk_oe_nxt, dat_oe_nxt;
  logic          clk_level, dat_level, fall;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clock_25  (clock_25),
    .RESET_N   (RESET_N),
    .clk_raw   (ps2_clk_in),
    .dat_raw   (ps2_dat_in),
    .clk_level (clk_level),
    .dat_level (dat_level),
    .fall      (fall)
  );

  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      state      <= IDLE;
      data_q     <= '0;
      parity_q   <= 1'b0;
      bitcnt_q   <= '0;
      timer_q    <= '0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_q     <= data_nxt;
      parity_q   <= parity_nxt;
      bitcnt_q   <= bitcnt_nxt;
      timer_q    <= timer_nxt;
      tx_busy    <= busy_nxt;
      tx_done    <= done_nxt;
      tx_error   <= error_nxt;
      ps2_clk_oe <= clk_oe_nxt;
      ps2_dat_oe <= dat_oe_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    data_nxt   = data_q;
    parity_nxt = parity_q;
    bitcnt_nxt = bitcnt_q;
    timer_clr  = 1'b0;
    go_err     = 1'b0;
    busy_nxt   = tx_busy;
    done_nxt   = 1'b0;
    error_nxt  = 1'b0;
    clk_oe_nxt = ps2_clk_oe;
    dat_oe_nxt = ps2_dat_oe;

    unique case (state)
      IDLE: begin
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b0;
        // The done cycle itself still counts as busy for new requests.
        if (tx_start && !tx_done) begin
          data_nxt   = tx_data;
          parity_nxt = odd_parity(tx_data);
          bitcnt_nxt = '0;
          busy_nxt   = 1'b1;
          clk_oe_nxt = 1'b1;
          timer_clr  = 1'b1;
          state_nxt  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timer_q == INH_LAST) begin
          clk_oe_nxt = 1'b0;
          timer_clr  = 1'b1;
          state_nxt  = WAIT_FIRST;
        end else if (timer_q == START_AT) begin
          dat_oe_nxt = 1'b1;
        end
      end
      WAIT_FIRST: begin
        if (fall) begin
          dat_oe_nxt = ~data_q[0];
          bitcnt_nxt = 4'd1;
          timer_clr  = 1'b1;
          state_nxt  = SHIFT;
        end else if (timer_q >= FIRST_LAST) begin
          go_err = 1'b1;
        end
      end
      SHIFT: begin
        if (fall) begin
          timer_clr  = 1'b1;
          bitcnt_nxt = bitcnt_q + 4'd1;
          if (bitcnt_q <= 4'd7) begin
            dat_oe_nxt = ~data_q[bitcnt_q[2:0]];
          end else if (bitcnt_q == 4'd8) begin
            dat_oe_nxt = ~parity_q;
          end else begin
            dat_oe_nxt = 1'b0;
            state_nxt  = ACK;
          end
        end else if (timer_q >= EDGE_LAST) begin
          go_err = 1'b1;
        end
      end
      ACK: begin
        if (fall) begin
          if (!dat_level) begin
            timer_clr = 1'b1;
            state_nxt = WAIT_IDLE;
          end else begin
            go_err = 1'b1;
          end
        end else if (timer_q >= EDGE_LAST) begin
          go_err = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_level && dat_level) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (timer_q >= EDGE_LAST) begin
          go_err = 1'b1;
        end
      end
      ERR: begin
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Error is registered on entry so the pulse, line release and busy drop share the ERR cycle.
    if (go_err) begin
      state_nxt  = ERR;
      error_nxt  = 1'b1;
      busy_nxt   = 1'b0;
      clk_oe_nxt = 1'b0;
      dat_oe_nxt = 1'b0;
    end

    if (timer_clr) begin
      timer_nxt = '0;
    end else if (timer_q == {TW{1'b1}}) begin
      timer_nxt = timer_q;
    end else begin
      timer_nxt = timer_q + TW'(1);
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: an open-drain PS/2 device model clocks frames,
// a reference model predicts each frame and result, and a monitor checks every pulse.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int FT   = 600;
  localparam int ET   = 300;
  localparam int HALF = 40;

  localparam int M_NORMAL   = 0;
  localparam int M_NOACK    = 1;
  localparam int M_NOCLK    = 2;
  localparam int M_STALL    = 3;
  localparam int M_GLITCH   = 4;
  localparam int M_MIDSTART = 5;
  localparam int M_RESET    = 6;

  typedef struct packed {
    logic        is_err;
    logic        chk_frame;
    logic [10:0] frame;
    logic [1:0]  lat_mode;
  } exp_t;

  logic       clock_25 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       clk_pin, dat_pin;

  exp_t        exp_q[$];
  logic [10:0] last_frame = '0;
  int          cyc = 0;
  int          rel_cyc = 0;
  int          stall_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  assign clk_pin = ~(ps2_clk_oe | dev_clk_low);
  assign dat_pin = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .FIRST_TIMEOUT  (FT),
    .EDGE_TIMEOUT   (ET),
    .FILTER_LEN     (8)
  ) dut (
    .clock_25   (clock_25),
    .RESET_N    (RESET_N),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (clk_pin),
    .ps2_dat_in (dat_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #20 clock_25 = ~clock_25;
  always @(posedge clock_25) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Frame as the device sees it: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2) == 0;
    return {1'b1, par, d, 1'b0};
  endfunction

  initial begin : monitor
    exp_t e;
    logic prev_oe;
    int   run;
    int   d;
    prev_oe = 1'b0;
    run = 0;
    forever begin
      @(negedge clock_25);
      if (ps2_clk_oe === 1'b1) begin
        run++;
      end else if (prev_oe === 1'b1) begin
        check("inhibit_len", run, INH);
        rel_cyc = cyc;
        run = 0;
      end
      prev_oe = ps2_clk_oe;
      if (tx_done === 1'b1 || tx_error === 1'b1) begin
        check("done_error_exclusive", {31'd0, tx_done & tx_error}, 0);
        check("busy_low_at_pulse", {31'd0, tx_busy}, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: done=%0b error=%0b, expected no pulse", tx_done, tx_error);
        end else begin
          e = exp_q.pop_front();
          check("result_is_error", {31'd0, tx_error}, {31'd0, e.is_err});
          if (e.chk_frame) check("frame_bits", {21'd0, last_frame}, {21'd0, e.frame});
          if (e.is_err) check("oe_released_on_error", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
          if (e.lat_mode == 2'd1) check("first_timeout_latency", cyc - rel_cyc, FT);
          if (e.lat_mode == 2'd2) begin
            d = cyc - stall_cyc;
            check("edge_timeout_window", {31'd0, (d >= ET && d <= ET + 24)}, 1);
          end
        end
      end
    end
  end

  task automatic start_tx(input logic [7:0] d);
    @(negedge clock_25);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock_25);
    tx_start = 1'b0;
  endtask

  // Device side: clocks 11 pulses, samples DAT on each rising edge, drives ACK.
  task automatic device(input int mode, input int arg);
    logic [10:0] bits;
    int t;
    bits = '0;
    t = 0;
    while (!(clk_pin === 1'b1 && dat_pin === 1'b0) && t < INH + 200) begin
      @(negedge clock_25);
      t++;
    end
    check("host_release_with_start", {31'd0, (clk_pin === 1'b1 && dat_pin === 1'b0)}, 1);
    if (mode == M_NOCLK) return;
    repeat (HALF) @(negedge clock_25);
    bits[0] = dat_pin;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && mode != M_NOACK) begin
        dev_dat_low = 1'b1;
        repeat (10) @(negedge clock_25);
      end
      dev_clk_low = 1'b1;
      if (mode == M_STALL && k == arg) begin
        stall_cyc = cyc;
        repeat (HALF) @(negedge clock_25);
        dev_clk_low = 1'b0;
        return;
      end
      if (mode == M_RESET && k == arg) begin
        repeat (20) @(negedge clock_25);
        check("busy_before_reset", {31'd0, tx_busy}, 1);
        RESET_N = 1'b0;
        @(negedge clock_25);
        check("reset_mid_frame_outputs",
              {27'd0, tx_busy, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error}, 0);
        RESET_N = 1'b1;
        dev_clk_low = 1'b0;
        return;
      end
      if (mode == M_MIDSTART && k == arg) begin
        repeat (5) @(negedge clock_25);
        tx_data  = ~tx_data;
        tx_start = 1'b1;
        @(negedge clock_25);
        tx_start = 1'b0;
        repeat (HALF - 6) @(negedge clock_25);
      end else begin
        repeat (HALF) @(negedge clock_25);
      end
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = dat_pin;
      if (k == 10) last_frame = bits;
      if (k == 11) begin
        repeat (5) @(negedge clock_25);
        dev_dat_low = 1'b0;
      end else if (mode == M_GLITCH && k == arg) begin
        repeat (15) @(negedge clock_25);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clock_25);
        dev_clk_low = 1'b0;
        repeat (HALF - 18) @(negedge clock_25);
      end else begin
        repeat (HALF) @(negedge clock_25);
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < FT + ET + 2000) begin
      @(negedge clock_25);
      t++;
    end
    check("result_arrived", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input int mode, input int arg);
    exp_t e;
    e.is_err    = (mode == M_NOACK || mode == M_NOCLK || mode == M_STALL);
    e.chk_frame = (mode == M_NORMAL || mode == M_GLITCH || mode == M_MIDSTART || mode == M_NOACK);
    e.frame     = ref_frame(d);
    e.lat_mode  = (mode == M_NOCLK) ? 2'd1 : (mode == M_STALL) ? 2'd2 : 2'd0;
    if (mode != M_RESET) exp_q.push_back(e);
    start_tx(d);
    device(mode, arg);
    drain();
    repeat (10) @(negedge clock_25);
  endtask

  initial begin : stimulus
    RESET_N = 1'b0;
    repeat (4) @(negedge clock_25);
    check("reset_outputs", {27'd0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 0);
    RESET_N = 1'b1;
    repeat (20) @(negedge clock_25);

    send(8'hED, M_NORMAL, 0);
    send(8'h01, M_NORMAL, 0);
    send(8'h00, M_NORMAL, 0);
    for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)), M_NORMAL, 0);
    send(8'($urandom_range(0, 255)), M_NOACK, 0);
    send(8'($urandom_range(0, 255)), M_NOCLK, 0);
    send(8'($urandom_range(0, 255)), M_STALL, 5);
    send(8'($urandom_range(0, 255)), M_GLITCH, 4);
    send(8'h3C, M_MIDSTART, 3);
    send(8'($urandom_range(0, 255)), M_RESET, 6);
    send(8'hFF, M_NORMAL, 0);

    repeat (50) @(negedge clock_25);
    check("idle_at_end", {30'd0, tx_busy, ps2_clk_oe}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    repeat (80000) @(posedge clock_25);
    $display("FAIL watchdog: simulation exceeded 80000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
